// File: rtl/registro_pontos_pkg.sv
// Shared types and constants for the score register block.
// Debounce counters are enabled with the macro REGISTRO_PONTOS_DEBOUNCE_EN.
package registro_pontos_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ATUALIZA = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  localparam int LARGURA_PONTOS    = 7;
  localparam int MAX_PONTOS_PADRAO = 99;
  localparam int DEB_CYCLES_PADRAO = 16;

  localparam logic [1:0] PESO_BTN0 = 2'd1;
  localparam logic [1:0] PESO_BTN1 = 2'd2;
  localparam logic [1:0] PESO_BTN2 = 2'd3;

  // Highest-index pressed button wins when several press in the same cycle.
  function automatic logic [1:0] peso_prioridade(input logic [2:0] press);
    logic [1:0] peso;
    peso = 2'd0;
    if (press[2])      peso = PESO_BTN2;
    else if (press[1]) peso = PESO_BTN1;
    else if (press[0]) peso = PESO_BTN0;
    return peso;
  endfunction

endpackage

// File: rtl/registro_pontos_debounce_btn.sv
// One button channel: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce counter present only when REGISTRO_PONTOS_DEBOUNCE_EN is defined.
module debounce_btn #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic nivel,
  output logic pulso
);

  logic s1;
  logic s2;
  logic nivel_d;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 1023) begin : g_deb_fora_faixa
    $error("debounce_btn: DEB_CYCLES out of range 2..1023");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef REGISTRO_PONTOS_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);

  logic [CW-1:0] cnt;

  // Level flips only after DEB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      nivel <= 1'b0;
    end else if (s2 != nivel) begin
      if (cnt == CW'(DEB_CYCLES - 1)) begin
        nivel <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign nivel = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nivel_d <= 1'b0;
    else     nivel_d <= nivel;
  end

  assign pulso = nivel & ~nivel_d;

endmodule

// File: rtl/registro_pontos.sv
// Saturating score register driven by three weighted buttons (+/-1, 2, 3).
// Optional debounce counters enabled by REGISTRO_PONTOS_DEBOUNCE_EN.
module registro_pontos
  import registro_pontos_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_PADRAO,
  parameter int MAX_PONTOS = MAX_PONTOS_PADRAO
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                btn,
  input  logic                      sinal,
  output logic [LARGURA_PONTOS-1:0] pontos,
  output logic                      valido,
  output logic                      alerta
);

  if (MAX_PONTOS < 1 || MAX_PONTOS > 127) begin : g_max_fora_faixa
    $error("registro_pontos: MAX_PONTOS out of range 1..127");
  end

  logic [2:0] nivel;
  logic [2:0] press;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    debounce_btn #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .nivel(nivel[i]),
      .pulso(press[i])
    );
  end

  estado_t                   estado,   estado_n;
  logic [1:0]                peso,     peso_n;
  logic [LARGURA_PONTOS-1:0] pontos_n;
  logic                      valido_n;
  logic                      alerta_n;
  logic [7:0]                soma;
  logic [7:0]                dif;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
      peso   <= 2'd0;
      pontos <= '0;
      valido <= 1'b0;
      alerta <= 1'b0;
    end else begin
      estado <= estado_n;
      peso   <= peso_n;
      pontos <= pontos_n;
      valido <= valido_n;
      alerta <= alerta_n;
    end
  end

  // 8-bit arithmetic: a negative difference always sets bit 7 since pontos <= 127.
  assign soma = {1'b0, pontos} + {6'd0, peso};
  assign dif  = {1'b0, pontos} - {6'd0, peso};

  always_comb begin
    estado_n = estado;
    peso_n   = peso;
    pontos_n = pontos;
    valido_n = 1'b0;
    alerta_n = alerta;
    case (estado)
      OCIOSO: begin
        if (|press) begin
          peso_n   = peso_prioridade(press);
          estado_n = ATUALIZA;
        end
      end
      ATUALIZA: begin
        valido_n = 1'b1;
        estado_n = ESPERA;
        if (!sinal) begin
          if (soma > 8'(MAX_PONTOS)) begin
            pontos_n = LARGURA_PONTOS'(MAX_PONTOS);
            alerta_n = 1'b1;
          end else begin
            pontos_n = soma[LARGURA_PONTOS-1:0];
          end
        end else begin
          if (dif[7]) begin
            pontos_n = '0;
            alerta_n = 1'b1;
          end else begin
            pontos_n = dif[LARGURA_PONTOS-1:0];
          end
        end
      end
      ESPERA: begin
        if (nivel == 3'b000) estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_registro_pontos.sv
// Self-checking bench for registro_pontos: table vectors, corner sequences, random presses.
// Expected debounce delay follows REGISTRO_PONTOS_DEBOUNCE_EN.
module tb_registro_pontos;

  localparam int DEB = 4;
  localparam int MAXP = 99;
`ifdef REGISTRO_PONTOS_DEBOUNCE_EN
  localparam int DEB_EFETIVO = DEB;
  localparam bit DEB_ATIVO = 1'b1;
`else
  localparam int DEB_EFETIVO = 0;
  localparam bit DEB_ATIVO = 1'b0;
`endif
  localparam int FASE = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic       sinal = 1'b0;
  logic [6:0] pontos;
  logic       valido;
  logic       alerta;

  int errors = 0;
  int checks = 0;
  int glitches = 0;
  int overRange = 0;

  registro_pontos #(
    .DEB_CYCLES(DEB),
    .MAX_PONTOS(MAXP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .sinal (sinal),
    .pontos(pontos),
    .valido(valido),
    .alerta(alerta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mask;
    logic       s;
    int         expPontos;
    int         expAlerta;
    int         expPulses;
  } vetor_t;

  vetor_t tabela[15];

  task automatic checkOutput(input string nome, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", nome, actual, expected);
    end
  endtask

  // Hold a button pattern for a number of cycles, counting valido-high cycles.
  task automatic applyStimulus(input logic [2:0] mask, input logic s, input int cycles,
                               output int pulses);
    int prev;
    pulses = 0;
    prev = int'(pontos);
    btn = mask;
    sinal = s;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (valido) pulses++;
      else if (int'(pontos) != prev) glitches++;
      if (int'(pontos) > MAXP) overRange++;
      prev = int'(pontos);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    btn = 3'b000;
    sinal = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset pontos", int'(pontos), 0);
    checkOutput("reset valido", int'(valido), 0);
    checkOutput("reset alerta", int'(alerta), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic int pesoRef(input logic [2:0] m);
    if (m[2]) return 3;
    if (m[1]) return 2;
    if (m[0]) return 1;
    return 0;
  endfunction

  initial begin
    int pl, p2, tot, lat;
    int mp, ma, w;
    logic [2:0] m;
    logic s;

    tabela[0]  = '{3'b100, 1'b0, 3, 0, 1};
    tabela[1]  = '{3'b000, 1'b0, 3, 0, 0};
    tabela[2]  = '{3'b101, 1'b0, 6, 0, 1};
    tabela[3]  = '{3'b001, 1'b0, 6, 0, 0};
    tabela[4]  = '{3'b000, 1'b0, 6, 0, 0};
    tabela[5]  = '{3'b001, 1'b0, 7, 0, 1};
    tabela[6]  = '{3'b000, 1'b0, 7, 0, 0};
    tabela[7]  = '{3'b100, 1'b1, 4, 0, 1};
    tabela[8]  = '{3'b000, 1'b1, 4, 0, 0};
    tabela[9]  = '{3'b010, 1'b1, 2, 0, 1};
    tabela[10] = '{3'b000, 1'b1, 2, 0, 0};
    tabela[11] = '{3'b100, 1'b1, 0, 1, 1};
    tabela[12] = '{3'b000, 1'b1, 0, 1, 0};
    tabela[13] = '{3'b001, 1'b1, 0, 1, 1};
    tabela[14] = '{3'b000, 1'b1, 0, 1, 0};

    @(negedge clk);
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tabela[i].mask, tabela[i].s, FASE, pl);
      checkOutput($sformatf("tab%0d pulses", i), pl, tabela[i].expPulses);
      checkOutput($sformatf("tab%0d pontos", i), int'(pontos), tabela[i].expPontos);
      checkOutput($sformatf("tab%0d alerta", i), int'(alerta), tabela[i].expAlerta);
    end

    // Reset in ESPERA with btn[0] held, then a single +1 after resync and debounce.
    applyStimulus(3'b001, 1'b0, FASE, pl);
    checkOutput("pre-rst pontos", int'(pontos), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst pontos", int'(pontos), 0);
    checkOutput("async rst valido", int'(valido), 0);
    checkOutput("async rst alerta", int'(alerta), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    tot = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (valido) begin
        tot++;
        if (lat == 0) lat = k;
      end
    end
    checkOutput("rst-held latency", lat, 4 + DEB_EFETIVO);
    checkOutput("rst-held pulses", tot, 1);
    checkOutput("rst-held pontos", int'(pontos), 1);
    applyStimulus(3'b000, 1'b0, FASE, pl);

    // Climb to 98, then clamp at the ceiling.
    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(3'b100, 1'b0, FASE, pl);
      applyStimulus(3'b000, 1'b0, FASE, p2);
    end
    checkOutput("climb pontos", int'(pontos), 96);
    applyStimulus(3'b010, 1'b0, FASE, pl);
    applyStimulus(3'b000, 1'b0, FASE, p2);
    checkOutput("to98 pontos", int'(pontos), 98);
    checkOutput("to98 alerta", int'(alerta), 0);
    applyStimulus(3'b010, 1'b0, FASE, pl);
    applyStimulus(3'b000, 1'b0, FASE, p2);
    checkOutput("clamp pontos", int'(pontos), 99);
    checkOutput("clamp alerta", int'(alerta), 1);
    checkOutput("clamp pulses", pl + p2, 1);
    applyStimulus(3'b001, 1'b0, FASE, pl);
    applyStimulus(3'b000, 1'b0, FASE, p2);
    checkOutput("atmax pontos", int'(pontos), 99);
    checkOutput("atmax pulses", pl + p2, 1);
    checkOutput("atmax alerta", int'(alerta), 1);

    // btn[1] chatter toggling every 2 cycles, then stable high; subtract mode.
    tot = 0;
    sinal = 1'b1;
    for (int i = 0; i < 30; i++) begin
      btn = (((i / 2) % 2) == 0) ? 3'b010 : 3'b000;
      @(negedge clk);
      if (valido) tot++;
    end
    applyStimulus(3'b010, 1'b1, FASE, pl);
    applyStimulus(3'b000, 1'b1, FASE, p2);
    tot = tot + pl + p2;
    if (DEB_ATIVO) begin
      checkOutput("chatter pulses", tot, 1);
      checkOutput("chatter pontos", int'(pontos), 97);
    end else begin
      checkOutput("chatter multi", int'(tot > 1), 1);
      checkOutput("chatter pontos", int'(pontos), 99 - 2 * tot);
    end

    // Random presses against a plain-arithmetic score model.
    doReset();
    mp = 0;
    ma = 0;
    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(0, 7));
      s = 1'($urandom_range(0, 1));
      applyStimulus(m, s, FASE, pl);
      applyStimulus(3'b000, s, FASE, p2);
      w = pesoRef(m);
      if (w != 0) begin
        if (!s) begin
          if (mp + w > MAXP) begin mp = MAXP; ma = 1; end
          else mp = mp + w;
        end else begin
          if (mp - w < 0) begin mp = 0; ma = 1; end
          else mp = mp - w;
        end
      end
      checkOutput($sformatf("rnd%0d pulses", i), pl + p2, (w != 0) ? 1 : 0);
      checkOutput($sformatf("rnd%0d pontos", i), int'(pontos), mp);
      checkOutput($sformatf("rnd%0d alerta", i), int'(alerta), ma);
    end

    checkOutput("pontos changed without valido", glitches, 0);
    checkOutput("pontos above ceiling", overRange, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
